// File: rtl/delay_pkg.sv
// delay_pkg: shared types, defaults and the length-to-target clamp for delay_sched.
package delay_pkg;
  localparam int DEF_CBITS = 14;
  localparam int DEF_N     = 12500;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  // A zero-length request still needs one cycle so done never collides with gnt.
  function automatic logic [31:0] clamp_len(input logic [31:0] l, input logic [31:0] n);
    return (l == 32'd0) ? 32'd1 : ((l > n) ? n : l);
  endfunction
endpackage

// File: rtl/delay_sched_rr_arb.sv
// rr_arb: combinational round-robin pick, first set request at or after ptr with wrap-around.
module rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_gnt,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_valid
);
  localparam int IW = $clog2(NREQ);

  logic w_found;

  assign o_valid = |i_req;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % NREQ]) begin
        w_found                             = 1'b1;
        o_idx                               = IW'((int'(i_ptr) + k) % NREQ);
        o_gnt[(int'(i_ptr) + k) % NREQ]     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/delay_sched.sv
// delay_sched: one programmable delay counter shared round-robin between NREQ requesters;
// done pulses exactly target cycles after the owner's grant.
module delay_sched
  import delay_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CBITS = DEF_CBITS,
  parameter int N     = DEF_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CBITS-1:0]   len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] cur_id,
  output logic                    clamp,
  output logic                    err
);
  localparam int IW = $clog2(NREQ);

  if (N < 1 || N >= (1 << CBITS)) begin : g_bad_n
    $error("delay_sched: N must be in 1..2**CBITS-1");
  end

  state_t           r_state;
  logic [CBITS-1:0] r_cnt;
  logic [CBITS-1:0] r_target;
  logic [IW-1:0]    r_ptr;

  logic [NREQ-1:0]  w_win;
  logic [IW-1:0]    w_idx;
  logic             w_valid;
  logic [CBITS-1:0] w_len;
  logic [CBITS-1:0] w_target;
  logic [IW-1:0]    w_ptr_nxt;

  rr_arb #(.NREQ(NREQ)) u_arb (
    .i_req  (req),
    .i_ptr  (r_ptr),
    .o_gnt  (w_win),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );

  assign w_len     = len[w_idx*CBITS +: CBITS];
  assign w_target  = CBITS'(clamp_len(32'(w_len), 32'(N)));
  assign w_ptr_nxt = (cur_id == IW'(NREQ - 1)) ? '0 : cur_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_ptr    <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      cur_id   <= '0;
      clamp    <= 1'b0;
      err      <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= (r_cnt > r_target) || (r_state == COUNT && r_target == '0);
      case (r_state)
        IDLE: if (w_valid) begin
          gnt      <= w_win;
          cur_id   <= w_idx;
          r_target <= w_target;
          clamp    <= w_len > CBITS'(N);
          r_cnt    <= CBITS'(1);
          busy     <= 1'b1;
          r_state  <= COUNT;
        end
        COUNT: if (r_cnt == r_target) begin
          done    <= NREQ'(1) << cur_id;
          r_state <= DONE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          r_ptr   <= w_ptr_nxt;
          r_cnt   <= '0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/delay_sched.md
Name: delay_sched

Overview:
- Shares one programmable delay counter between NREQ requesters.
- Each requester asks for a delay of len cycles; a round-robin arbiter grants the counter to one requester at a time.
- The block counts the granted delay and pulses done back to the owner.
- Sits in front of the delay/timeout datapath, replacing per-client free-running delay counters.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CBITS, 14, counter and length width
- N, 12500, maximum permitted delay in cycles; requests above N are clamped

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- req  input  NREQ  level request per requester; held until gnt
- len  input  NREQ*CBITS  requested delay per requester, slice i = len[i*CBITS +: CBITS]
- gnt  output  NREQ  one-hot, one-cycle grant pulse
- done  output  NREQ  one-hot, one-cycle completion pulse to the owner
- busy  output  1  counter owned (state != IDLE)
- cur_id  output  $clog2(NREQ)  owner index; valid while busy
- clamp  output  1  latched at grant: requested len > N
- err  output  1  internal invariant violation; must never assert

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, ptr=0, target=0; gnt=0, done=0, busy=0, cur_id=0, clamp=0, err=0. A reset mid-count abandons the delay silently; no done is produced.
- All outputs are registered.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If req != 0, the winner is the first set bit at or after ptr, with wrap-around.
  - Next edge: gnt[winner]=1 for one cycle, cur_id=winner, state=COUNT, cnt=1.
  - target = 1 if len=0; N if len>N (clamp=1); else len (clamp=0).
  - If req=0, stay in IDLE.
- COUNT:
  - cnt increments by 1 each cycle.
  - When cnt==target, the next edge enters DONE and asserts done[cur_id] for one cycle.
  - Net timing: done rises exactly target cycles after gnt rises (gnt in cycle G, done in cycle G+target).
  - target=1 means done in the cycle immediately after gnt.
- DONE: one cycle. ptr=(cur_id+1) mod NREQ, cnt=0, then IDLE. New arbitration happens in IDLE, so grants are spaced by at least target+2 cycles.
- Request rules:
  - req and len are sampled only in IDLE.
  - A requester must keep len stable while req is high.
  - A requester must drop req in the cycle after gnt.
  - A req still high after its done is treated as a new request and competes normally.
  - A req withdrawn before gnt receives nothing.
  - Requests arriving during COUNT or DONE wait; none are lost while held.
- Fairness: a requester holding req is granted within NREQ arbitrations.
- Arithmetic: cnt and target are CBITS-wide unsigned; N must fit in CBITS (static check). Comparisons are unsigned, and cnt never wraps.
- err (registered) = 1 in any cycle where cnt > target, or where state=COUNT and target=0.
- Required property: after the first cycle out of reset, err stays 0 forever.
- Additional properties:
  - gnt and done are each one-hot or zero.
  - done is never asserted in the same cycle as gnt.
  - busy=0 implies done=0.
- Simultaneous events: if all req bits rise together, the grant order is ptr, ptr+1, ... in strict rotation.

Decomposition:
- Package delay_pkg holds:
  - the state enum (IDLE, COUNT, DONE)
  - default CBITS and N localparams
  - the clamp function (len -> target)
- Sub-module rr_arb: combinational round-robin pick from (req, ptr) to a one-hot winner plus index, with parameter NREQ.
- Counter, FSM and ptr stay in delay_sched.

Test Plan:
- Reset release, no req for 100 cycles -> all outputs 0, busy=0, err=0 throughout.
- Single requester, req[0]=1, len=5 -> gnt[0] at cycle G, done[0] at G+5, busy high G..G+5, clamp=0.
- Boundaries, each on requester 1:
  - len=0 -> done at G+1.
  - len=12500 -> done at G+12500, clamp=0.
  - len=16383 -> done at G+12500, clamp=1, err=0.
- All four req high together, len=3 each, ptr=0 -> grant order 0,1,2,3, then 0 again if still held; each done 3 cycles after its gnt; gnt spacing 5 cycles.
- rst pulsed low during COUNT at cnt=7 of len=20 -> outputs return to reset values immediately; no done[]. A re-request after release is granted from ptr=0.
- Random req/len for 10^5 cycles -> err never 1, every held req granted within 4 arbitrations, done count equals gnt count.
